// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: holds the fetch address and chooses the next PC from increment, branch, jump/call, RAS return, trap entry or trap return.
// Latency: one cycle from a redirect or advance sampled at an edge to the new pc; every output is registered.
// Backpressure: pc holds while fetch_valid=1 and fetch_ready=0; a redirect overrides a fetch that has not been accepted.
//
// Ports:
//   clock, reset_n                     clock and asynchronous active-low reset
//   fetch_valid/fetch_ready, pc        fetch request handshake towards instruction memory
//   branch_taken/branch_target         resolved taken branch
//   jump/call/jump_target              unconditional jump; with call, the link is pushed onto the RAS
//   ret/ret_target                     return via RAS top, or via ret_target when the RAS is empty
//   trap/mret, epc                     trap entry/return and the saved trap PC
//   halt/resume, halted                halt control
//   ras_empty/ras_full                 RAS occupancy flags
module pc_sequencer #(
  parameter int                XLEN         = 32,
  parameter logic [XLEN-1:0]   RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0]   TRAP_VECTOR  = 32'h0000_0080,
  parameter int                INSTR_BYTES  = 4,
  parameter int                RAS_DEPTH    = 4
) (
  input  logic            clock,
  input  logic            reset_n,
  output logic            fetch_valid,
  input  logic            fetch_ready,
  output logic [XLEN-1:0] pc,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jump,
  input  logic            call,
  input  logic [XLEN-1:0] jump_target,
  input  logic            ret,
  input  logic [XLEN-1:0] ret_target,
  input  logic            trap,
  input  logic            mret,
  input  logic            halt,
  input  logic            resume,
  output logic [XLEN-1:0] epc,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            halted
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH) + 1;

  localparam logic [XLEN-1:0] INC        = XLEN'(INSTR_BYTES);
  // Clears the low log2(INSTR_BYTES) bits of every loaded target.
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(INSTR_BYTES - 1));
  localparam logic [CW-1:0]   CNT_FULL   = CW'(RAS_DEPTH);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] pc_nxt, epc_nxt;
  logic [XLEN-1:0] pc_inc;

  // Return-address stack: ras_ptr names the current top entry.
  logic [XLEN-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]   ras_ptr;
  logic [PW-1:0]   ras_ptr_inc;
  logic [CW-1:0]   ras_cnt;
  logic [XLEN-1:0] ras_top;
  logic            ras_push, ras_pop, ras_ovw;

  // Wraps modulo 2^XLEN; also used as the call link.
  assign pc_inc      = pc + INC;
  assign ras_ptr_inc = ras_ptr + PW'(1);
  assign ras_top     = ras_mem[ras_ptr];
  assign ras_empty   = (ras_cnt == '0);
  assign ras_full    = (ras_cnt == CNT_FULL);

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    epc_nxt   = epc;
    ras_push  = 1'b0;
    ras_pop   = 1'b0;
    ras_ovw   = 1'b0;
    unique case (state)
      ST_BOOT: state_nxt = ST_RUN;
      ST_RUN: begin
        if (trap) begin
          epc_nxt = pc;
          pc_nxt  = TRAP_VECTOR;
        end else if (mret) begin
          pc_nxt = epc & ALIGN_MASK;
        end else if (branch_taken) begin
          pc_nxt = branch_target & ALIGN_MASK;
        end else if (jump) begin
          pc_nxt = jump_target & ALIGN_MASK;
          // call+ret together replaces the top entry instead of pop-then-push.
          if (call) begin
            if (ret) ras_ovw  = 1'b1;
            else     ras_push = 1'b1;
          end
        end else if (ret) begin
          if (!ras_empty) begin
            pc_nxt  = ras_top & ALIGN_MASK;
            ras_pop = 1'b1;
          end else begin
            pc_nxt = ret_target & ALIGN_MASK;
          end
        end else if (halt) begin
          state_nxt = ST_HALT;
        end else if (fetch_ready) begin
          pc_nxt = pc_inc;
        end
      end
      ST_HALT: begin
        if (trap) begin
          epc_nxt   = pc;
          pc_nxt    = TRAP_VECTOR;
          state_nxt = ST_RUN;
        end else if (resume) begin
          state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_BOOT;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_BOOT;
      pc          <= RESET_VECTOR;
      epc         <= '0;
      fetch_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      epc         <= epc_nxt;
      fetch_valid <= (state_nxt == ST_RUN);
      halted      <= (state_nxt == ST_HALT);
    end
  end

  // A push when full advances the pointer over the oldest entry; the count saturates.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
    end else if (ras_push) begin
      ras_ptr <= ras_ptr_inc;
      if (!ras_full) ras_cnt <= ras_cnt + CW'(1);
    end else if (ras_pop) begin
      ras_ptr <= ras_ptr - PW'(1);
      ras_cnt <= ras_cnt - CW'(1);
    end
  end

  // Entry contents are don't-care after reset, so the array has no reset.
  always_ff @(posedge clock) begin
    if (ras_push)     ras_mem[ras_ptr_inc] <= pc_inc;
    else if (ras_ovw) ras_mem[ras_ptr]     <= pc_inc;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the processor's instruction-fetch stage. It holds the current fetch address, issues it to instruction memory with a valid/ready handshake, and selects the next PC from sequential increment, branch, jump/call, return-address-stack pop, trap entry or trap return. It also keeps an exception PC (EPC) register and a circular return-address stack (RAS).

## Interface
Parameters:
- XLEN, 32, address width in bits.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- TRAP_VECTOR, 32'h0000_0080, PC value loaded on trap entry.
- INSTR_BYTES, 4, sequential increment; power of two, at least 1.
- RAS_DEPTH, 4, return-address-stack entries; power of two, at least 2.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- fetch_valid  out  1  pc is a valid fetch request.
- fetch_ready  in  1  instruction memory accepts pc this cycle.
- pc  out  XLEN  current fetch address (registered).
- branch_taken  in  1  conditional branch resolved taken.
- branch_target  in  XLEN  branch destination.
- jump  in  1  unconditional jump.
- call  in  1  push link on the RAS; only meaningful together with jump.
- jump_target  in  XLEN  jump/call destination.
- ret  in  1  return; target comes from the RAS.
- ret_target  in  XLEN  fallback return target when the RAS is empty.
- trap  in  1  exception/interrupt entry.
- mret  in  1  return from trap.
- halt  in  1  request halt.
- resume  in  1  leave halt.
- epc  out  XLEN  saved trap PC.
- ras_empty  out  1  RAS count is 0.
- ras_full  out  1  RAS count is RAS_DEPTH.
- halted  out  1  FSM is in HALT.

## Operation
- Reset values: pc=RESET_VECTOR, epc=0, fetch_valid=0, RAS count=0 (ras_empty=1, ras_full=0), halted=0, state=BOOT. RAS entry contents are don't-care.
- FSM states:
  - BOOT: all inputs are ignored. Moves to RUN on the next edge.
  - RUN: fetch_valid=1.
  - HALT: fetch_valid=0 and halted=1.
- RUN next-PC priority, highest first; exactly one action per cycle:
  1. trap: epc←pc, pc←TRAP_VECTOR.
  2. mret: pc←epc.
  3. branch_taken: pc←branch_target.
  4. jump: pc←jump_target. If call=1, push pc+INSTR_BYTES.
  5. ret: if the RAS is non-empty, pc←top and pop. If empty, pc←ret_target and the count stays 0.
  6. halt: go to HALT; pc holds.
  7. fetch_ready: pc←pc+INSTR_BYTES.
  8. Otherwise: hold (stall).
- Redirects (items 1–5) take effect regardless of fetch_ready. A pending fetch that is not accepted is dropped.
- jump+call+ret in the same cycle: pc←jump_target, the top entry is overwritten with the link, and the count is unchanged. Lower-priority inputs asserted in the same cycle are ignored.
- All loaded targets (branch, jump, RAS, ret_target, mret) have their low log2(INSTR_BYTES) bits forced to 0.
- Arithmetic: pc+INSTR_BYTES wraps modulo 2^XLEN (all-ones-aligned + INSTR_BYTES → 0). The link is computed with the same wrap.
- RAS is circular with a top pointer and a count:
  - Push when full overwrites the oldest entry; the count stays RAS_DEPTH.
  - Pop when empty does not change the pointer or the count.
- HALT:
  - trap performs trap entry and returns to RUN.
  - resume returns to RUN with pc unchanged.
  - All other inputs are ignored.
- reset_n low at any time immediately forces all reset values, including mid-redirect and mid-halt.

## Timing
- Single clock domain. pc, epc, fetch_valid, halted and RAS flags are all registered.
- Redirect latency is one cycle: a target sampled at edge N appears on pc after edge N.
- Handshake: a fetch is accepted on an edge where fetch_valid=1 and fetch_ready=1. pc is held stable while fetch_valid=1 and fetch_ready=0, unless a redirect occurs.
- After reset_n deasserts: first edge → RUN (pc=RESET_VECTOR, fetch_valid=1). The first advance happens no earlier than the second edge.
- ras_empty and ras_full update on the same edge as the push/pop.
- No combinational path from any input to any output.

## Test plan
- Reset then fetch_ready=1 for 4 cycles → pc sequence 0x0, 0x0, 0x4, 0x8, 0xC (BOOT cycle first); hold fetch_ready=0 → pc holds at 0xC.
- At pc=0x10, assert trap with branch_taken=1, branch_target=0x200 → pc=0x80, epc=0x10. Then mret → pc=0x10.
- Call chain: calls from 0x100, 0x200, 0x300, 0x400, 0x500 (RAS_DEPTH=4) → ras_full=1. Four rets → pc 0x504, 0x404, 0x304, 0x204. A fifth ret with ret_target=0x999 → pc=0x998, ras_empty=1.
- pc=32'hFFFF_FFFC with fetch_ready=1 → pc=0x0. A call at that pc pushes link 0x0.
- halt at pc=0x40 → fetch_valid=0, halted=1, pc=0x40 held; jump ignored. trap → pc=0x80, RUN. Repeat the halt, then resume → pc unchanged, fetch_valid=1.
- Assert reset_n low mid-RUN with RAS count 2 and epc=0x10 → same cycle: pc=RESET_VECTOR, epc=0, fetch_valid=0, ras_empty=1.
